// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS stopwatch: FSM state encoding,
// BCD digit limits and a single-digit BCD increment with carry-out.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_RUN,
    SW_PAUSE
  } sw_state_t;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  typedef struct packed {
    logic [3:0] value;
    logic       carry;
  } bcd_inc_t;

  // Anything at or above the limit is treated as the wrap point so a corrupted
  // digit falls back into range on its next advance.
  function automatic bcd_inc_t bcd_inc(input logic [3:0] value, input logic [3:0] max);
    bcd_inc_t r;
    if (value >= max) begin
      r.value = 4'd0;
      r.carry = 1'b1;
    end else begin
      r.value = value + 4'd1;
      r.carry = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton path: two-flop synchroniser, counting debouncer and rising-edge
// detector. press is a registered one-cycle pulse when the stable level goes high.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      // The DEBOUNCE_CYCLES-th consecutive differing cycle accepts the new level.
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch: debounced start/stop and clear buttons, a prescaler producing
// the count tick, and a four-digit BCD cascade that wraps at 59:59.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int unsigned DIV    = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
  localparam bit          CFG_OK = (TICK_HZ != 0) && (DIV >= 2) && (DIV * TICK_HZ == CLK_HZ);
  localparam int unsigned PW     = (DIV > 2) ? $clog2(DIV) : 1;

  if (!CFG_OK) begin : g_bad_cfg
    $error("stopwatch_bcd: CLK_HZ must be an exact multiple of TICK_HZ with a ratio of at least 2");
  end

  logic          start_press, clear_press;
  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    dig_q   [4];
  logic [3:0]    dig_d   [4];
  logic [3:0]    inc_val [4];
  logic [4:0]    carry;
  logic          advance;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_start),
    .level  (),
    .press  (start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clear (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_clear),
    .level  (),
    .press  (clear_press)
  );

  // dig_q[0] is seconds; even positions are units, odd positions are tens.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    localparam logic [3:0] DMAX = (gi % 2 == 0) ? BCD_MAX_UNITS : BCD_MAX_TENS;
    bcd_inc_t inc;
    assign inc          = bcd_inc(dig_q[gi], DMAX);
    assign inc_val[gi]  = inc.value;
    assign carry[gi+1]  = carry[gi] & inc.carry;
  end

  assign advance = (state_q == SW_RUN) && (presc_q == PW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];

    if (state_q == SW_RUN) begin
      if (advance) begin
        presc_d = '0;
        tick_d  = 1'b1;
        wrap_d  = carry[4];
        for (int i = 0; i < 4; i++) begin
          if (carry[i]) dig_d[i] = inc_val[i];
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    case (state_q)
      SW_IDLE:  if (start_press) state_d = SW_RUN;
      SW_RUN:   if (start_press) state_d = SW_PAUSE;
      SW_PAUSE: if (start_press) state_d = SW_RUN;
      default:  state_d = SW_IDLE;
    endcase

    // Clear overrides everything on this edge, including a coincident tick or start.
    if (clear_press) begin
      state_d = SW_IDLE;
      presc_d = '0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      for (int i = 0; i < 4; i++) dig_d[i] = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SW_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign d0      = dig_q[0];
  assign d1      = dig_q[1];
  assign d2      = dig_q[2];
  assign d3      = dig_q[3];
  assign running = (state_q == SW_RUN);
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule
